// File: rtl/regs_pkg.sv
// Shared definitions for the register-file write arbiter: default widths,
// register address type, hardwired-zero address and requester ids.
package regs_pkg;

    localparam int DW_DEF = 8;
    localparam int AW_DEF = 3;

    typedef logic [AW_DEF-1:0] reg_addr_t;

    localparam reg_addr_t R0 = '0;

    typedef enum logic {
        PRI_REQ0 = 1'b0,
        PRI_REQ1 = 1'b1
    } req_pri_t;

endpackage

// File: rtl/regs_arb_rr.sv
// Two-input grant logic for the register-file write port.
// REGS_ARB_RR_EN selects round-robin; otherwise requester 0 has fixed priority.
//
// state    | meaning
// PRI_REQ0 | requester 0 wins the next contended cycle
// PRI_REQ1 | requester 1 wins the next contended cycle
module regs_arb_rr
    import regs_pkg::*;
(
`ifdef REGS_ARB_RR_EN
    input  logic clk,
`endif
    input  logic reset,
    input  logic valid0_i,
    input  logic valid1_i,
    output logic gnt0_o,
    output logic gnt1_o
);

`ifdef REGS_ARB_RR_EN
    req_pri_t ptr_q, ptr_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= PRI_REQ0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // The pointer only moves on contention, so a lone requester never steals a turn.
    always_comb begin
        gnt0_o = 1'b0;
        gnt1_o = 1'b0;
        ptr_d  = ptr_q;
        if (!reset) begin
            if (valid0_i && valid1_i) begin
                if (ptr_q == PRI_REQ0) begin
                    gnt0_o = 1'b1;
                    ptr_d  = PRI_REQ1;
                end else begin
                    gnt1_o = 1'b1;
                    ptr_d  = PRI_REQ0;
                end
            end else begin
                gnt0_o = valid0_i;
                gnt1_o = valid1_i;
            end
        end
    end
`else
    always_comb begin
        gnt0_o = valid0_i & ~reset;
        gnt1_o = valid1_i & ~valid0_i & ~reset;
    end
`endif

endmodule

// File: rtl/regs_wr_arb.sv
// Register-file write arbiter: one accept per cycle, registered write port,
// r0 write dropping with a saturating counter, and read-after-write hazard flags.
// Optional round-robin arbitration via REGS_ARB_RR_EN.
module regs_wr_arb
    import regs_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0_valid,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_data,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_data,
    output logic          req1_ready,
    input  logic [AW-1:0] raddr1,
    input  logic [AW-1:0] raddr2,
    output logic          w,
    output logic [AW-1:0] waddr,
    output logic [DW-1:0] wdata,
    output logic          hit1,
    output logic          hit2,
    output logic [7:0]    drop_cnt_q
);

    localparam logic [AW-1:0] ADDR_R0 = AW'(R0);

    logic          gnt0, gnt1;
    logic          accept;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_data;
    logic          w_q, w_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [7:0]    drop_cnt_d;

    regs_arb_rr u_arb (
`ifdef REGS_ARB_RR_EN
        .clk      (clk),
`endif
        .reset    (reset),
        .valid0_i (req0_valid),
        .valid1_i (req1_valid),
        .gnt0_o   (gnt0),
        .gnt1_o   (gnt1)
    );

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign accept     = gnt0 | gnt1;
    assign sel_addr   = gnt1 ? req1_addr : req0_addr;
    assign sel_data   = gnt1 ? req1_data : req0_data;

    // Writes to r0 are consumed but never reach the port; waddr/wdata hold otherwise.
    always_comb begin
        w_d        = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        drop_cnt_d = drop_cnt_q;
        if (accept) begin
            if (sel_addr != ADDR_R0) begin
                w_d     = 1'b1;
                waddr_d = sel_addr;
                wdata_d = sel_data;
            end else if (drop_cnt_q != 8'hFF) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_q        <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            drop_cnt_q <= 8'h00;
        end else begin
            w_q        <= w_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign w     = w_q;
    assign waddr = waddr_q;
    assign wdata = wdata_q;

    assign hit1 = w_q && (waddr_q == raddr1) && (raddr1 != ADDR_R0);
    assign hit2 = w_q && (waddr_q == raddr2) && (raddr2 != ADDR_R0);

endmodule

// File: doc/regs_wr_arb.md
REGS_WR_ARB -- requirements
Module: regs_wr_arb

Interface
REQ-001 Parameter DW, 8, data width of register-file write data.
REQ-002 Parameter AW, 3, register address width (8 registers, r0 hardwired zero).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req0_valid  input  1  requester 0 (ALU writeback) has a write pending.
REQ-006 req0_addr  input  AW  requester 0 destination register.
REQ-007 req0_data  input  DW  requester 0 write data.
REQ-008 req0_ready  output  1  requester 0 write accepted this cycle (combinational).
REQ-009 req1_valid, req1_addr, req1_data, req1_ready  same directions/widths  requester 1 (I/O load unit).
REQ-010 raddr1, raddr2  input  AW each  read addresses currently presented to the register file.
REQ-011 w, waddr, wdata  output  1/AW/DW  registered write port driving the register file.
REQ-012 hit1, hit2  output  1 each  in-flight write targets raddr1/raddr2 (read-after-write hazard).
REQ-013 drop_cnt_q  output  8  count of accepted writes to r0.

Function
REQ-014 Accept exactly one request per cycle; reqN_ready SHALL equal grant to N, asserted only when reqN_valid=1.
REQ-015 Both valid: winner chosen by arbitration policy (REQ-026); loser ready=0 and SHALL hold valid/addr/data stable until accepted.
REQ-016 Single valid: that requester granted immediately, regardless of pointer.
REQ-017 Accepted request with addr!=0: next cycle w=1, waddr/wdata = accepted values (latency 1, exactly one w pulse per accept).
REQ-018 Accepted request with addr==0: ready still asserted (write consumed), w stays 0 next cycle, drop_cnt_q increments by 1, saturating at 8'hFF.
REQ-019 No accept in a cycle: w=0 next cycle; waddr/wdata hold previous values.
REQ-020 hit1 = w & (waddr==raddr1) & (raddr1!=0); hit2 likewise for raddr2; combinational, no hit ever for r0.
REQ-021 Back-to-back accepts to same address: two consecutive w pulses, in accept order; no merging.
REQ-022 Round-robin pointer (when enabled) SHALL advance to the non-winning requester only on a cycle where both were valid; single-valid grants leave it unchanged.

Reset
REQ-023 Reset SHALL force next cycle: w=0, waddr=0, wdata=0, drop_cnt_q=0, RR pointer=requester 0.
REQ-024 During reset cycle reqN_ready=0 for both; any in-flight write is discarded (no w pulse after reset).
REQ-025 Reset dominates simultaneous valid requests.

Configuration
REQ-026 Macro REGS_ARB_RR_EN: defined -> round-robin between requesters per REQ-022; undefined -> fixed priority, requester 0 always wins, pointer logic absent.

Structure
REQ-027 Shared package regs_pkg SHALL hold DW/AW defaults, register-address typedef, and constant R0 address.
REQ-028 One sub-module regs_arb_rr (2-input grant + pointer) is natural; write stage, hazard compare and counter in top.

Verification
REQ-029 Reset, then req0 valid addr=1 data=A5 alone -> ready0=1 same cycle; next cycle w=1 waddr=1 wdata=A5; following cycle w=0.
REQ-030 Both valid (req0 addr=2 data=11, req1 addr=3 data=22) held 2 cycles, RR_EN -> r0 wins first, r1 second; w pulses addr 2 then 3; without RR_EN req0 wins both cycles while held.
REQ-031 req1 addr=0 data=FF -> ready1=1, w stays 0, drop_cnt_q 0->1; 256 such writes -> drop_cnt_q=FF.
REQ-032 Write addr=4 accepted, raddr1=4 raddr2=0 during w cycle -> hit1=1 hit2=0; next cycle hit1=0.
REQ-033 Reset asserted the cycle after an accept -> no w pulse, all outputs zero, pointer back to requester 0.
